hub75_scan_sequencer: RTL

//  Scan controller for the 64x32 HUB75 LED panel (two half-panel rows per scan line).

---
 rtl/hub75_pkg.sv | 25 ++
 rtl/hub75_on_timer.sv | 76 +++++++
 rtl/hub75_scan_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types and defaults for the HUB75 scan sequencer.
//   state_e  - scan FSM states
//   rgb3_t   - one {R,G,B} pixel triple
//   COLS_DEFAULT / ROW_BITS_DEFAULT - panel geometry defaults (64x32, two halves)
//   COL_W    - width of the pix_col port
// Optional feature macro used by this block: HUB75_DIM_EN (global brightness).
package hub75_pkg;

    localparam int unsigned COLS_DEFAULT     = 64;
    localparam int unsigned ROW_BITS_DEFAULT = 4;
    localparam int unsigned COL_W            = 7;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSetup,
        StClk,
        StBlank,
        StLatch,
        StShow
    } state_e;

    typedef logic [2:0] rgb3_t;

endpackage

// File: rtl/hub75_on_timer.sv
// hub75_on_timer: per-line display timer for the HUB75 scan sequencer.
// Loads when the row is latched, counts the SHOW cycles, flags the last one, and says
// whether OE should be active in the current SHOW cycle.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   load_i         - restart the count (LATCH cycle); also samples brightness_i
//   run_i          - a SHOW cycle is in progress
//   brightness_i   - global dim level (only with HUB75_DIM_EN)
//   done_o         - current SHOW cycle is the last one
//   oe_active_o    - OE should be driven active in this SHOW cycle
// Config macro: HUB75_DIM_EN. Without it OE is active for the whole SHOW period.
module hub75_on_timer #(
    parameter int unsigned ON_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       run_i,
`ifdef HUB75_DIM_EN
    input  logic [7:0] brightness_i,
`endif
    output logic       done_o,
    output logic       oe_active_o
);

    localparam int unsigned CntW = $clog2(ON_CYCLES + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(ON_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = run_i && (cnt_q == LastCnt);

`ifdef HUB75_DIM_EN
    // Number of leading SHOW cycles with OE active, fixed for the whole line.
    logic [CntW-1:0] on_len_q, on_len_d;
    logic [39:0]     on_prod;

    always_comb begin
        on_prod  = 40'(ON_CYCLES) * 40'(brightness_i);
        on_len_d = on_len_q;
        if (load_i) begin
            on_len_d = CntW'(on_prod >> 8);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            on_len_q <= '0;
        end else begin
            on_len_q <= on_len_d;
        end
    end

    assign oe_active_o = (cnt_q < on_len_q);
`else
    assign oe_active_o = 1'b1;
`endif

endmodule

// File: rtl/hub75_scan_sequencer.sv
// hub75_scan_sequencer: scan controller for a 64x32 HUB75 panel (two half-panel rows
// per scan line). Fetches pixel pairs over a req/valid handshake, shifts them out with a
// generated shift clock, blanks and latches the row, then displays it for ON_CYCLES.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   enable               - run the scan; when low the block parks blanked after the line
//   pix_req/row/col      - pixel-pair request to the frame source
//   pix_valid/top/bot    - source response; only looked at while fetching
//   r0,g0,b0 / r1,g1,b1  - upper / lower half data pins
//   sclk, lat, oe_n      - panel shift clock, latch, active-low output enable
//   addr                 - displayed line address {D,C,B,A}
//   frame_done           - one-cycle pulse after the last line's display ends
//   brightness           - global dim level (only with HUB75_DIM_EN)
// Config macro: HUB75_DIM_EN enables the brightness port and dimmed OE.
// All outputs are registers or decodes of registered state.
module hub75_scan_sequencer
    import hub75_pkg::*;
#(
    parameter int unsigned COLS      = COLS_DEFAULT,
    parameter int unsigned ROW_BITS  = ROW_BITS_DEFAULT,
    parameter int unsigned ON_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    output logic                pix_req,
    output logic [ROW_BITS-1:0] pix_row,
    output logic [COL_W-1:0]    pix_col,
    input  logic                pix_valid,
    input  logic [2:0]          pix_top,
    input  logic [2:0]          pix_bot,
`ifdef HUB75_DIM_EN
    input  logic [7:0]          brightness,
`endif
    output logic                r0,
    output logic                g0,
    output logic                b0,
    output logic                r1,
    output logic                g1,
    output logic                b1,
    output logic                sclk,
    output logic                lat,
    output logic                oe_n,
    output logic [ROW_BITS-1:0] addr,
    output logic                frame_done
);

    localparam logic [COL_W-1:0] ColLast = COL_W'(COLS - 1);

    state_e              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [ROW_BITS-1:0] addr_q, addr_d;
    rgb3_t               top_q, top_d;
    rgb3_t               bot_q, bot_d;
    logic                frame_done_q, frame_done_d;

    logic timer_load;
    logic timer_run;
    logic show_done;
    logic oe_active;

    assign timer_load = (state_q == StLatch);
    assign timer_run  = (state_q == StShow);

    hub75_on_timer #(
        .ON_CYCLES (ON_CYCLES)
    ) u_on_timer (
        .clk          (clk),
        .rst          (rst),
        .load_i       (timer_load),
        .run_i        (timer_run),
`ifdef HUB75_DIM_EN
        .brightness_i (brightness),
`endif
        .done_o       (show_done),
        .oe_active_o  (oe_active)
    );

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        addr_d       = addr_q;
        top_d        = top_q;
        bot_d        = bot_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (pix_valid) begin
                    top_d   = pix_top;
                    bot_d   = pix_bot;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                state_d = StClk;
            end
            StClk: begin
                if (col_q == ColLast) begin
                    col_d   = '0;
                    state_d = StBlank;
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = StFetch;
                end
            end
            StBlank: begin
                addr_d  = row_q;
                state_d = StLatch;
            end
            StLatch: begin
                state_d = StShow;
            end
            StShow: begin
                if (show_done) begin
                    row_d        = row_q + 1'b1;
                    frame_done_d = &row_q;
                    // enable is only honoured at line boundaries
                    state_d      = enable ? StFetch : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            col_q        <= '0;
            row_q        <= '0;
            addr_q       <= '0;
            top_q        <= '0;
            bot_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            addr_q       <= addr_d;
            top_q        <= top_d;
            bot_q        <= bot_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pix_req    = (state_q == StFetch);
    assign pix_row    = row_q;
    assign pix_col    = col_q;
    assign sclk       = (state_q == StClk);
    assign lat        = (state_q == StLatch);
    assign oe_n       = !((state_q == StShow) && oe_active);
    assign addr       = addr_q;
    assign frame_done = frame_done_q;
    assign {r0, g0, b0} = top_q;
    assign {r1, g1, b1} = bot_q;

endmodule
